// File: rtl/ad4003_adc_emulator_if.sv
// rtl/ad4003_adc_emulator_if.sv - AD4003 3-wire serial bus between host deserializer and emulator
interface ad4003_adc_emulator_if;
  logic cnv;
  logic sck;
  logic sdi;
  logic sdo;

  modport master (output cnv, output sck, output sdi, input sdo);
  modport slave  (input cnv, input sck, input sdi, output sdo);
endinterface

// File: rtl/ad4003_adc_emulator.sv
// rtl/ad4003_adc_emulator.sv - AD4003 serial slave emulator; AD4003_EMU_STATUS_EN appends 6 status bits
module ad4003_adc_emulator #(
  parameter int unsigned CONV_CYCLES = 29,
  parameter logic [7:0]  CFG_RESET   = 8'hE1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk_100,
  input  logic                rst_n,
  ad4003_adc_emulator_if.slave bus,
  input  logic [17:0]         sample_in,
  output logic                sample_req,
  output logic [7:0]          cfg_reg,
  output logic                busy,
  output logic                frame_err
);
  localparam int unsigned   TW         = $clog2(CONV_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(CONV_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CONV, WAIT_CS, SHIFT} state_e;

  logic [SYNC_STAGES-1:0] cnv_sync_q, sck_sync_q, sdi_sync_q;
  logic                   cnv_prev_q, sck_prev_q;
  logic                   cnv_s, sck_s, sdi_s;
  logic                   cnv_rise, sck_rise, sck_fall;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [17:0]   shadow_q, shadow_d;
  logic [23:0]   shift_q, shift_d;
  logic [15:0]   cmd_q, cmd_d;
  logic [4:0]    sck_cnt_q, sck_cnt_d;
  logic          read_pending_q, read_pending_d;
  logic [7:0]    cfg_q, cfg_d;
  logic          sample_req_q, sample_req_d;
  logic          frame_err_q, frame_err_d;
  logic          start;
  logic          frame_end, cnt_bad, cmd_ok, cmd_write, cmd_read;
  logic [5:0]    status;

  assign cnv_s    = cnv_sync_q[SYNC_STAGES-1];
  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign sdi_s    = sdi_sync_q[SYNC_STAGES-1];
  assign cnv_rise = cnv_s & ~cnv_prev_q;
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;

  // Frame-end decode: clock counts 1..15 and 19..23 are malformed and suppress any command.
  assign frame_end = (state_q == SHIFT) && cnv_rise;
  assign cnt_bad   = ((sck_cnt_q != 5'd0) && (sck_cnt_q < 5'd16)) ||
                     ((sck_cnt_q > 5'd18) && (sck_cnt_q < 5'd24));
  assign cmd_ok    = frame_end && !cnt_bad && (sck_cnt_q >= 5'd16);
  assign cmd_write = cmd_ok && (cmd_q[15:8] == 8'h14);
  assign cmd_read  = cmd_ok && (cmd_q[15:8] == 8'h54);

`ifdef AD4003_EMU_STATUS_EN
  logic reg_wr_q;
  logic ov;

  assign ov     = (shadow_q == 18'h1FFFF) || (shadow_q == 18'h20000);
  assign status = cfg_q[4] ? {ov, reg_wr_q, cfg_q[1], cfg_q[2], 2'b00} : 6'b0;

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      reg_wr_q <= 1'b0;
    end else if (frame_end) begin
      reg_wr_q <= cmd_write;
    end
  end
`else
  assign status = 6'b0;
`endif

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      cnv_sync_q     <= '0;
      sck_sync_q     <= '0;
      sdi_sync_q     <= '0;
      cnv_prev_q     <= 1'b0;
      sck_prev_q     <= 1'b0;
      state_q        <= IDLE;
      timer_q        <= '0;
      shadow_q       <= '0;
      shift_q        <= '0;
      cmd_q          <= '0;
      sck_cnt_q      <= '0;
      read_pending_q <= 1'b0;
      cfg_q          <= CFG_RESET;
      sample_req_q   <= 1'b0;
      frame_err_q    <= 1'b0;
    end else begin
      cnv_sync_q     <= {cnv_sync_q[SYNC_STAGES-2:0], bus.cnv};
      sck_sync_q     <= {sck_sync_q[SYNC_STAGES-2:0], bus.sck};
      sdi_sync_q     <= {sdi_sync_q[SYNC_STAGES-2:0], bus.sdi};
      cnv_prev_q     <= cnv_s;
      sck_prev_q     <= sck_s;
      state_q        <= state_d;
      timer_q        <= timer_d;
      shadow_q       <= shadow_d;
      shift_q        <= shift_d;
      cmd_q          <= cmd_d;
      sck_cnt_q      <= sck_cnt_d;
      read_pending_q <= read_pending_d;
      cfg_q          <= cfg_d;
      sample_req_q   <= sample_req_d;
      frame_err_q    <= frame_err_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    shadow_d       = shadow_q;
    shift_d        = shift_q;
    cmd_d          = cmd_q;
    sck_cnt_d      = sck_cnt_q;
    read_pending_d = read_pending_q;
    cfg_d          = cfg_q;
    sample_req_d   = 1'b0;
    frame_err_d    = 1'b0;
    start          = 1'b0;

    case (state_q)
      IDLE: start = cnv_rise;
      CONV: begin
        if (timer_q == '0) begin
          state_d = WAIT_CS;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      WAIT_CS: begin
        if (cnv_rise) begin
          start = 1'b1;
        end else if (!cnv_s) begin
          shift_d        = read_pending_q ? {cfg_q, 10'b0, status} : {shadow_q, status};
          read_pending_d = 1'b0;
          state_d        = SHIFT;
        end
      end
      SHIFT: begin
        // cnv rise wins over any sck edge decoded in the same cycle.
        if (cnv_rise) begin
          frame_err_d = cnt_bad;
          if (cmd_write) cfg_d = cmd_q[7:0];
          if (cmd_read) read_pending_d = 1'b1;
          cmd_d     = '0;
          sck_cnt_d = '0;
          start     = 1'b1;
        end else begin
          if (sck_fall) shift_d = {shift_q[22:0], 1'b0};
          if (sck_rise) begin
            cmd_d = {cmd_q[14:0], sdi_s};
            if (sck_cnt_q != 5'd31) sck_cnt_d = sck_cnt_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      shadow_d     = sample_in;
      sample_req_d = 1'b1;
      timer_d      = TIMER_LOAD;
      state_d      = CONV;
    end
  end

  assign bus.sdo    = (state_q == SHIFT) && shift_q[23];
  assign busy       = (state_q == CONV);
  assign sample_req = sample_req_q;
  assign frame_err  = frame_err_q;
  assign cfg_reg    = cfg_q;
endmodule

// File: tb/tb_ad4003_adc_emulator.sv
// tb/tb_ad4003_adc_emulator.sv - self-checking bench for ad4003_adc_emulator with a frame-level reference model
module tb_ad4003_adc_emulator;
  logic        clk_100 = 1'b0;
  logic        rst_n;
  logic [17:0] sample_in;
  logic        sample_req;
  logic [7:0]  cfg_reg;
  logic        busy;
  logic        frame_err;

  ad4003_adc_emulator_if bus_if();

  ad4003_adc_emulator dut (
    .clk_100   (clk_100),
    .rst_n     (rst_n),
    .bus       (bus_if),
    .sample_in (sample_in),
    .sample_req(sample_req),
    .cfg_reg   (cfg_reg),
    .busy      (busy),
    .frame_err (frame_err)
  );

  always #5 clk_100 = ~clk_100;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state, tracked per frame rather than per clock.
  logic [7:0]  m_cfg;
  bit          m_pending;
  logic [17:0] m_shadow;
  bit          m_wrflag;
  bit          m_in_frame;
  int          m_n;
  logic [15:0] m_cmd;
  logic [23:0] m_expect;
  logic [23:0] rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cfg      = 8'hE1;
    m_pending  = 0;
    m_shadow   = '0;
    m_wrflag   = 0;
    m_in_frame = 0;
    m_n        = 0;
    m_cmd      = '0;
    m_expect   = '0;
  endtask

  function automatic logic [23:0] model_frame_data();
    logic [5:0]  st;
    logic [17:0] d;
    st = 6'b0;
    d  = m_pending ? {m_cfg, 10'b0} : m_shadow;
`ifdef AD4003_EMU_STATUS_EN
    if (m_cfg[4]) st = {(m_shadow == 18'h1FFFF || m_shadow == 18'h20000), m_wrflag, m_cfg[1], m_cfg[2], 2'b00};
`endif
    return {d, st};
  endfunction

  // Raise cnv (ending any open frame), watch the conversion, then drop cnv to open the next frame.
  task automatic cnv_pulse(input logic [17:0] s);
    bit exp_err;
    bit bad;
    int n_req, n_busy, n_err;
    exp_err = 0;
    n_req = 0;
    n_busy = 0;
    n_err = 0;
    if (m_in_frame) begin
      bad      = (m_n > 0 && m_n < 16) || (m_n > 18 && m_n < 24);
      exp_err  = bad;
      m_wrflag = 0;
      if (!bad && m_n >= 16) begin
        if (m_cmd[15:8] == 8'h14) begin
          m_cfg    = m_cmd[7:0];
          m_wrflag = 1;
        end else if (m_cmd[15:8] == 8'h54) begin
          m_pending = 1;
        end
      end
    end
    m_shadow   = s;
    sample_in  = s;
    bus_if.cnv = 1'b1;
    repeat (45) begin
      @(negedge clk_100);
      if (sample_req === 1'b1) n_req++;
      if (busy === 1'b1) n_busy++;
      if (frame_err === 1'b1) n_err++;
    end
    check("sample_req_pulses", n_req, 1);
    check("busy_cycles", n_busy, 29);
    check("frame_err_pulses", n_err, {31'b0, exp_err});
    check("cfg_reg", {24'b0, cfg_reg}, {24'b0, m_cfg});
    bus_if.cnv = 1'b0;
    repeat (6) @(negedge clk_100);
    m_expect   = model_frame_data();
    m_pending  = 0;
    m_in_frame = 1;
    m_n        = 0;
    m_cmd      = '0;
  endtask

  // 8-cycle sck (12.5 MHz); sdi changes on the fall, sdo sampled just before each rise.
  task automatic shift_bits(input int n, input logic [15:0] word, output logic [23:0] r);
    logic [23:0] mask;
    r    = '0;
    mask = '0;
    for (int i = 0; i < n; i++) begin
      bus_if.sdi = (i < 16) ? word[15-i] : 1'b0;
      repeat (4) @(negedge clk_100);
      if (i < 24) begin
        r[23-i]    = bus_if.sdo;
        mask[23-i] = 1'b1;
      end
      bus_if.sck = 1'b1;
      m_cmd = {m_cmd[14:0], bus_if.sdi};
      if (m_n < 31) m_n++;
      repeat (4) @(negedge clk_100);
      bus_if.sck = 1'b0;
    end
    bus_if.sdi = 1'b0;
    repeat (4) @(negedge clk_100);
    if (n > 0) check($sformatf("sdo_frame_%0dclk", n), {8'b0, r & mask}, {8'b0, m_expect & mask});
  endtask

  initial begin
    int          kind;
    int          n;
    logic [15:0] w;
    logic [17:0] smp;

    rst_n      = 1'b0;
    bus_if.cnv = 1'b0;
    bus_if.sck = 1'b0;
    bus_if.sdi = 1'b0;
    sample_in  = '0;
    model_reset();
    repeat (3) @(negedge clk_100);
    check("rst_sdo", {31'b0, bus_if.sdo}, 0);
    check("rst_sample_req", {31'b0, sample_req}, 0);
    check("rst_cfg_reg", {24'b0, cfg_reg}, 32'hE1);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_frame_err", {31'b0, frame_err}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_100);

    cnv_pulse(18'h2A5A5);
    shift_bits(18, 16'h0000, rd);
    check("read_2A5A5", {14'b0, rd[23:6]}, 32'h2A5A5);
    cnv_pulse(18'h01234);

    shift_bits(16, 16'h1423, rd);
    cnv_pulse(18'h15555);
    check("cfg_after_write", {24'b0, cfg_reg}, 32'h23);
    shift_bits(16, 16'h5400, rd);
    cnv_pulse(18'h0AAAA);
    shift_bits(18, 16'h0000, rd);
    check("read_cfg_frame", {14'b0, rd[23:6]}, 32'h08C00);
    cnv_pulse(18'h3FFFF);

    shift_bits(10, 16'h14FF, rd);
    cnv_pulse(18'h00001);
    check("cfg_unchanged_short", {24'b0, cfg_reg}, 32'h23);

    cnv_pulse(18'h12345);
    shift_bits(18, 16'h0000, rd);
    check("read_second_sample", {14'b0, rd[23:6]}, 32'h12345);

    cnv_pulse(18'h0BEEF);
    shift_bits(9, 16'h14C3, rd);
    rst_n = 1'b0;
    repeat (2) @(negedge clk_100);
    check("midrst_cfg", {24'b0, cfg_reg}, 32'hE1);
    check("midrst_sdo", {31'b0, bus_if.sdo}, 0);
    check("midrst_busy", {31'b0, busy}, 0);
    rst_n = 1'b1;
    model_reset();
    repeat (2) @(negedge clk_100);
    cnv_pulse(18'h2C0DE);
    shift_bits(18, 16'h0000, rd);
    check("read_after_reset", {14'b0, rd[23:6]}, 32'h2C0DE);
    cnv_pulse(18'h00777);

`ifdef AD4003_EMU_STATUS_EN
    shift_bits(16, 16'h1412, rd);
    cnv_pulse(18'h00123);
    shift_bits(24, 16'h0000, rd);
    check("status_after_write", {26'b0, rd[5:0]}, 32'h18);
    cnv_pulse(18'h1FFFF);
    shift_bits(24, 16'h0000, rd);
    check("status_ov", {26'b0, rd[5:0]}, 32'h28);
    check("data_ov", {14'b0, rd[23:6]}, 32'h1FFFF);
    cnv_pulse(18'h00042);
`endif

    for (int it = 0; it < 14; it++) begin
      kind = $urandom_range(0, 5);
      w    = 16'($urandom);
      case (kind)
        0: n = 18;
        1: begin n = 16; w[15:8] = 8'h14; end
        2: begin n = 16; w = 16'h5400; end
        3: n = $urandom_range(1, 15);
        4: n = $urandom_range(19, 23);
        default: n = 24;
      endcase
      if (kind == 0 || kind == 5) w = 16'h0000;
      shift_bits(n, w, rd);
      smp = 18'($urandom);
      cnv_pulse(smp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
